// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. A request is granted
// in IDLE, its control code and operands are registered onto the ALU inputs
// (EXEC), the ALU result/zero flag are captured one cycle later, and the
// captured response is held for the granted requester (RESP) until it is
// taken. Arbitration is round-robin: after a response is taken the priority
// pointer moves to the other requester.
//
// Handshake semantics (both channels): a transfer happens on the rising edge
// of iClk where valid and ready are both 1. A valid source keeps its payload
// stable until that edge. Ready may depend combinationally on valid.
//
// Ports
//   iClk, iRstN                   clock, asynchronous active-low reset
//   iReqValid<n>/oReqReady<n>     request handshake, n = 0,1
//   iReqCtrl<n>, iReqOp1/2<n>     request payload (ALU code, operands)
//   oRspValid<n>/iRspReady<n>     response handshake
//   oRspResult<n>, oRspZero<n>    response payload (0 for non-granted side)
//   oAluControl, oAluOp1/2        registered drive to the shared ALU
//   iAluResult, iAluZero          combinational return from the shared ALU
//   oDbgState                     current FSM state (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int OP_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,

    input  logic                  iReqValid0,
    output logic                  oReqReady0,
    input  logic [OP_WIDTH-1:0]   iReqCtrl0,
    input  logic [DATA_WIDTH-1:0] iReqOp10,
    input  logic [DATA_WIDTH-1:0] iReqOp20,

    input  logic                  iReqValid1,
    output logic                  oReqReady1,
    input  logic [OP_WIDTH-1:0]   iReqCtrl1,
    input  logic [DATA_WIDTH-1:0] iReqOp11,
    input  logic [DATA_WIDTH-1:0] iReqOp21,

    output logic                  oRspValid0,
    input  logic                  iRspReady0,
    output logic [DATA_WIDTH-1:0] oRspResult0,
    output logic                  oRspZero0,

    output logic                  oRspValid1,
    input  logic                  iRspReady1,
    output logic [DATA_WIDTH-1:0] oRspResult1,
    output logic                  oRspZero1,

    output logic [OP_WIDTH-1:0]   oAluControl,
    output logic [DATA_WIDTH-1:0] oAluOp1,
    output logic [DATA_WIDTH-1:0] oAluOp2,
    input  logic [DATA_WIDTH-1:0] iAluResult,
    input  logic                  iAluZero,

    output logic [1:0]            oDbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    pri_q, pri_d;
    logic                    gnt_q, gnt_d;
    logic [OP_WIDTH-1:0]     alu_ctrl_q, alu_ctrl_d;
    logic [DATA_WIDTH-1:0]   alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH-1:0]   alu_op2_q, alu_op2_d;
    logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                    rsp_zero_q, rsp_zero_d;

    logic                    any_valid;
    logic                    winner;
    logic                    idle_live;
    logic                    rsp_taken;

    // Winner is the sole valid requester, or PRI when both are valid.
    always_comb begin
        any_valid = iReqValid0 | iReqValid1;
        if (iReqValid0 && iReqValid1) begin
            winner = pri_q;
        end else begin
            winner = iReqValid1;
        end
    end

    // Ready is also gated by reset so nothing looks acceptable while the
    // block is held in reset, even though the state already reads IDLE.
    always_comb begin
        idle_live  = (state_q == IDLE) && iRstN;
        oReqReady0 = idle_live && iReqValid0 && !winner;
        oReqReady1 = idle_live && iReqValid1 && winner;
        rsp_taken  = gnt_q ? iRspReady1 : iRspReady0;
    end

    always_comb begin
        state_d      = state_q;
        pri_d        = pri_q;
        gnt_d        = gnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            IDLE: begin
                // Any valid requester is accepted this edge: the winner's
                // ready is high whenever at least one valid is high.
                if (any_valid) begin
                    state_d    = EXEC;
                    gnt_d      = winner;
                    alu_ctrl_d = winner ? iReqCtrl1 : iReqCtrl0;
                    alu_op1_d  = winner ? iReqOp11  : iReqOp10;
                    alu_op2_d  = winner ? iReqOp21  : iReqOp20;
                end
            end
            EXEC: begin
                rsp_result_d = iAluResult;
                rsp_zero_d   = iAluZero;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_taken) begin
                    state_d = IDLE;
                    pri_d   = ~gnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q      <= IDLE;
            pri_q        <= 1'b0;
            gnt_q        <= 1'b0;
            alu_ctrl_q   <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pri_q        <= pri_d;
            gnt_q        <= gnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    // Response payload is steered to the granted side only and forced to 0
    // elsewhere, so a non-granted requester never sees stale data.
    always_comb begin
        oRspValid0  = (state_q == RESP) && !gnt_q;
        oRspValid1  = (state_q == RESP) && gnt_q;
        oRspResult0 = oRspValid0 ? rsp_result_q : '0;
        oRspZero0   = oRspValid0 && rsp_zero_q;
        oRspResult1 = oRspValid1 ? rsp_result_q : '0;
        oRspZero1   = oRspValid1 && rsp_zero_q;
        oAluControl = alu_ctrl_q;
        oAluOp1     = alu_op1_q;
        oAluOp2     = alu_op2_q;
        oDbgState   = state_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. Inputs change 1 ns after a rising edge; outputs and
// handshakes are observed on the falling edge. Each request pushes its
// expected {zero, result} onto a per-requester queue; the monitor pops and
// compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int OW = 4;
    localparam int DW = 32;
    localparam int EW = DW + 1;

    logic          iClk;
    logic          iRstN;
    logic          iReqValid0, iReqValid1;
    logic          oReqReady0, oReqReady1;
    logic [OW-1:0] iReqCtrl0, iReqCtrl1;
    logic [DW-1:0] iReqOp10, iReqOp20, iReqOp11, iReqOp21;
    logic          oRspValid0, oRspValid1;
    logic          iRspReady0, iRspReady1;
    logic [DW-1:0] oRspResult0, oRspResult1;
    logic          oRspZero0, oRspZero1;
    logic [OW-1:0] oAluControl;
    logic [DW-1:0] oAluOp1, oAluOp2;
    logic [DW-1:0] iAluResult;
    logic          iAluZero;
    logic [1:0]    oDbgState;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int            grant_log[$];
    int            acc_cyc0[$];

    typedef struct {
        int            side;
        logic [OW-1:0] ctrl;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] res;
        logic          zero;
    } vec_t;

    vec_t vecs[8];

    alu_arbiter #(.OP_WIDTH(OW), .DATA_WIDTH(DW)) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iReqValid0  (iReqValid0),
        .oReqReady0  (oReqReady0),
        .iReqCtrl0   (iReqCtrl0),
        .iReqOp10    (iReqOp10),
        .iReqOp20    (iReqOp20),
        .iReqValid1  (iReqValid1),
        .oReqReady1  (oReqReady1),
        .iReqCtrl1   (iReqCtrl1),
        .iReqOp11    (iReqOp11),
        .iReqOp21    (iReqOp21),
        .oRspValid0  (oRspValid0),
        .iRspReady0  (iRspReady0),
        .oRspResult0 (oRspResult0),
        .oRspZero0   (oRspZero0),
        .oRspValid1  (oRspValid1),
        .iRspReady1  (iRspReady1),
        .oRspResult1 (oRspResult1),
        .oRspZero1   (oRspZero1),
        .oAluControl (oAluControl),
        .oAluOp1     (oAluOp1),
        .oAluOp2     (oAluOp2),
        .iAluResult  (iAluResult),
        .iAluZero    (iAluZero),
        .oDbgState   (oDbgState)
    );

    // ---------------- shared ALU model ----------------
    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] c,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b1111: return 32'd5;
            default: return a ^ b;
        endcase
    endfunction

    assign iAluResult = alu_fn(oAluControl, oAluOp1, oAluOp2);
    assign iAluZero   = (iAluResult == '0);

    // ---------------- clock / reset ----------------
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    always @(posedge iClk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge iClk) begin
        if (iRstN) begin
            check("rsp_valid_onehot", 64'(oRspValid0 & oRspValid1), 64'(0));
            check("req_ready_onehot", 64'(oReqReady0 & oReqReady1), 64'(0));
            check("ready_during_rsp", 64'((oReqReady0 | oReqReady1) & (oRspValid0 | oRspValid1)), 64'(0));
            if (!oRspValid0) check("rsp0_idle_zero", 64'({oRspZero0, oRspResult0}), 64'(0));
            if (!oRspValid1) check("rsp1_idle_zero", 64'({oRspZero1, oRspResult1}), 64'(0));
            if (iReqValid0 && oReqReady0) begin
                grant_log.push_back(0);
                acc_cyc0.push_back(cyc + 1);
            end
            if (iReqValid1 && oReqReady1) grant_log.push_back(1);
            if (oRspValid0 && iRspReady0) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp0_unexpected: got %0h expected no response", {oRspZero0, oRspResult0});
                end else begin
                    check("rsp0_data", 64'({oRspZero0, oRspResult0}), 64'(exp_q0.pop_front()));
                end
            end
            if (oRspValid1 && iRspReady1) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp1_unexpected: got %0h expected no response", {oRspZero1, oRspResult1});
                end else begin
                    check("rsp1_data", 64'({oRspZero1, oRspResult1}), 64'(exp_q1.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raises a request and returns 1 ns after the edge that accepted it.
    // Valid is left high; the caller drops it or sends again.
    task automatic send(input int side, input logic [OW-1:0] c,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [EW-1:0] exp);
        bit accepted = 1'b0;
        if (side == 0) begin
            iReqValid0 = 1'b1; iReqCtrl0 = c; iReqOp10 = a; iReqOp20 = b;
            exp_q0.push_back(exp);
        end else begin
            iReqValid1 = 1'b1; iReqCtrl1 = c; iReqOp11 = a; iReqOp21 = b;
            exp_q1.push_back(exp);
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge iClk);
            if ((side == 0) ? oReqReady0 : oReqReady1) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: side %0d got no ready expected ready within 60 cycles", side);
        end
        @(posedge iClk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 60) begin
            @(posedge iClk);
            k++;
        end
        checks++;
        if (k >= 60) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
        end
        @(posedge iClk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{0, 4'b0000, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1, 4'b0001, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[2] = '{0, 4'b0010, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0};
        vecs[3] = '{1, 4'b0011, 32'd0,          32'd0,          32'd0,          1'b1};
        vecs[4] = '{0, 4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[5] = '{1, 4'b1111, 32'h1234,       32'h5678,       32'd5,          1'b0};
        vecs[6] = '{0, 4'b0001, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[7] = '{1, 4'b0000, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1};

        iRstN = 1'b0;
        iReqValid0 = 1'b1; iReqCtrl0 = '0; iReqOp10 = '0; iReqOp20 = '0;
        iReqValid1 = 1'b1; iReqCtrl1 = '0; iReqOp11 = '0; iReqOp21 = '0;
        iRspReady0 = 1'b1; iRspReady1 = 1'b1;

        // Reset values, with both requesters already valid.
        repeat (2) @(posedge iClk);
        #1;
        check("rst_ready0", 64'(oReqReady0), 64'(0));
        check("rst_ready1", 64'(oReqReady1), 64'(0));
        check("rst_rspv0", 64'(oRspValid0), 64'(0));
        check("rst_rspv1", 64'(oRspValid1), 64'(0));
        check("rst_alu_ctrl", 64'(oAluControl), 64'(0));
        check("rst_alu_op1", 64'(oAluOp1), 64'(0));
        check("rst_alu_op2", 64'(oAluOp2), 64'(0));
        check("rst_state", 64'(oDbgState), 64'(0));

        // Both valid across reset release: grants alternate 0,1,0,1.
        @(posedge iClk);
        #1 iRstN = 1'b1;
        fork
            begin
                send(0, 4'b0000, 32'd10, 32'd20, {1'b0, 32'd30});
                send(0, 4'b0001, 32'd50, 32'd8,  {1'b0, 32'd42});
            end
            begin
                send(1, 4'b0010, 32'hFF, 32'h0F, {1'b0, 32'h0F});
                send(1, 4'b0011, 32'd0,  32'd0,  {1'b1, 32'd0});
            end
        join
        iReqValid0 = 1'b0;
        iReqValid1 = 1'b0;
        drain();
        check("rr_grant_count", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("rr_grant_%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Single transaction timing: accept at T, EXEC until T+1, response
        // visible before edge T+2.
        send(0, 4'b0000, 32'd5, 32'd7, {1'b0, 32'd12});
        check("lat_alu_ctrl", 64'(oAluControl), 64'(0));
        check("lat_alu_op1", 64'(oAluOp1), 64'(5));
        check("lat_alu_op2", 64'(oAluOp2), 64'(7));
        check("lat_ready_exec", 64'(oReqReady0), 64'(0));
        iReqValid0 = 1'b0;
        @(negedge iClk);
        check("lat_state_exec", 64'(oDbgState), 64'(1));
        check("lat_rspv_exec", 64'(oRspValid0), 64'(0));
        @(negedge iClk);
        check("lat_rspv_resp", 64'(oRspValid0), 64'(1));
        check("lat_result", 64'(oRspResult0), 64'(12));
        check("lat_zero", 64'(oRspZero0), 64'(0));
        drain();

        // Table vectors, one at a time, alternating sides.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].side, vecs[i].ctrl, vecs[i].op1, vecs[i].op2, {vecs[i].zero, vecs[i].res});
            check($sformatf("vec%0d_alu_ctrl", i), 64'(oAluControl), 64'(vecs[i].ctrl));
            check($sformatf("vec%0d_alu_op1", i), 64'(oAluOp1), 64'(vecs[i].op1));
            check($sformatf("vec%0d_alu_op2", i), 64'(oAluOp2), 64'(vecs[i].op2));
            iReqValid0 = 1'b0;
            iReqValid1 = 1'b0;
            drain();
        end

        // Back-pressure on requester 1 while requester 0 waits.
        iRspReady1 = 1'b0;
        send(1, 4'b0001, 32'd9, 32'd9, {1'b1, 32'd0});
        iReqValid1 = 1'b0;
        @(posedge iClk);
        #1;
        fork
            send(0, 4'b0000, 32'd1, 32'd2, {1'b0, 32'd3});
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            check($sformatf("bp%0d_rspv1", i), 64'(oRspValid1), 64'(1));
            check($sformatf("bp%0d_result1", i), 64'(oRspResult1), 64'(0));
            check($sformatf("bp%0d_zero1", i), 64'(oRspZero1), 64'(1));
            check($sformatf("bp%0d_ready0", i), 64'(oReqReady0), 64'(0));
            check($sformatf("bp%0d_state", i), 64'(oDbgState), 64'(2));
        end
        @(posedge iClk);
        #1 iRspReady1 = 1'b1;
        wait fork;
        iReqValid0 = 1'b0;
        drain();

        // Requester 0 continuously valid: accepts exactly 3 cycles apart.
        acc_cyc0.delete();
        for (int i = 0; i < 10; i++) begin
            logic [DW-1:0] a, b, s;
            a = $urandom;
            b = $urandom_range(0, 1000);
            s = a + b;
            send(0, 4'b0000, a, b, {(s == '0), s});
        end
        iReqValid0 = 1'b0;
        drain();
        check("stream_accepts", 64'(acc_cyc0.size()), 64'(10));
        for (int i = 1; i < acc_cyc0.size(); i++)
            check($sformatf("stream_gap_%0d", i), 64'(acc_cyc0[i] - acc_cyc0[i-1]), 64'(3));

        // Requester 1 valid only while the block is busy, then withdrawn.
        grant_log.delete();
        send(0, 4'b0011, 32'hA0, 32'h0B, {1'b0, 32'hAB});
        iReqValid0 = 1'b0;
        iReqValid1 = 1'b1; iReqCtrl1 = 4'b0000; iReqOp11 = 32'd1; iReqOp21 = 32'd1;
        @(posedge iClk);
        #1 iReqValid1 = 1'b0;
        drain();
        repeat (3) @(posedge iClk);
        #1;
        check("withdraw_grants", 64'(grant_log.size()), 64'(1));

        // Reset pulsed while a response is being held.
        iRspReady0 = 1'b0;
        send(0, 4'b0000, 32'd3, 32'd4, {1'b0, 32'd7});
        iReqValid0 = 1'b0;
        @(posedge iClk);
        #1;
        check("mid_rspv0_before", 64'(oRspValid0), 64'(1));
        iReqValid1 = 1'b1;
        #1 iRstN = 1'b0;
        #1;
        check("mid_rspv0", 64'(oRspValid0), 64'(0));
        check("mid_rspv1", 64'(oRspValid1), 64'(0));
        check("mid_ready0", 64'(oReqReady0), 64'(0));
        check("mid_ready1", 64'(oReqReady1), 64'(0));
        check("mid_alu_ctrl", 64'(oAluControl), 64'(0));
        check("mid_alu_op1", 64'(oAluOp1), 64'(0));
        check("mid_alu_op2", 64'(oAluOp2), 64'(0));
        exp_q0.delete();
        exp_q1.delete();
        iReqValid1 = 1'b0;
        iRspReady0 = 1'b1;
        @(posedge iClk);
        #1 iRstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            check($sformatf("post_rst%0d_rspv0", i), 64'(oRspValid0), 64'(0));
            check($sformatf("post_rst%0d_rspv1", i), 64'(oRspValid1), 64'(0));
        end
        @(posedge iClk);
        #1;
        grant_log.delete();
        fork
            send(0, 4'b0000, 32'd1, 32'd1, {1'b0, 32'd2});
            send(1, 4'b0000, 32'd2, 32'd2, {1'b0, 32'd4});
        join
        iReqValid0 = 1'b0;
        iReqValid1 = 1'b0;
        drain();
        check("post_rst_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() > 0)
            check("post_rst_first_grant", 64'(grant_log[0]), 64'(0));

        check("final_q0_empty", 64'(exp_q0.size()), 64'(0));
        check("final_q1_empty", 64'(exp_q1.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
